uart_tx_fifo: RTL and testbench

- Buffered 8N1 UART transmitter for the lab6 UART design.
- Accepts bytes from the functional logic through a write-strobe interface into a small FIFO.
- Serialises bytes onto the board `tx` line at a fixed baud rate, generating its own bit timing from the 50 MHz system clock.
- Counterpart of the UART receive path: complements the receive/display logic in `top_uart`, and its `tx` feeds the `RsTx` pin.

---
 rtl/uart_tx_fifo.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop serialiser
// that derives its own bit timing from the system clock.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] count;
  logic [FCNT_W-1:0] count_n;
  logic              push;
  logic              pop;

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [CNT_W-1:0]  baud_cnt;
  logic [CNT_W-1:0]  baud_n;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_n;
  logic [7:0]        shift;
  logic [7:0]        shift_n;
  logic              tx_n;
  logic              busy_n;
  logic              done_n;
  logic              baud_last;

  // FIFO bookkeeping; full/empty come from the registered flags so a write while full is dropped
  always_comb begin
    push    = wr_en && !full;
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + FCNT_W'(1);
      2'b01:   count_n = count - FCNT_W'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_n;
      full  <= (count_n == FIFO_FULL);
      empty <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Serialiser next-state logic; the popped byte is copied into shift so the FIFO head stays untouched
  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_n     = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    pop       = 1'b0;
    baud_last = (baud_cnt == BAUD_LAST);
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = S_START;
          baud_n  = '0;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (baud_last) begin
          state_n = S_DATA;
          bit_n   = 3'd0;
          baud_n  = '0;
          tx_n    = shift[0];
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift_n[0];
          end
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        if (baud_last) begin
          baud_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = S_START;
            tx_n    = 1'b0;
          end else begin
            state_n = S_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
    endcase
    busy_n = (state_n != S_IDLE);
    // registered tick lands on the last stop-bit cycle
    done_n = (state_n == S_STOP) && (baud_n == BAUD_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      baud_cnt     <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      baud_cnt     <= baud_n;
      bit_idx      <= bit_n;
      shift        <= shift_n;
      tx           <= tx_n;
      tx_busy      <= busy_n;
      tx_done_tick <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench: a line-level UART receiver model decodes tx and the
// expected byte stream comes from FIFO acceptance rules applied to the bytes written.
module tb_uart_tx_fifo;

  localparam int unsigned CPB   = 10;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic       clk;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       empty;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rx_q[$];
  int         gap_q[$];
  int         frames_seen = 0;
  int         done_cnt    = 0;
  int         cyc         = 0;

  uart_tx_fifo #(
    .CLK_FREQ  (50_000_000),
    .BAUD      (5_000_000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .empty       (empty),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tx_done_tick) done_cnt <= done_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference receiver: frame start is the first low cycle; bits sampled at mid-bit
  initial begin : rx_model
    int         last_end;
    int         start_cyc;
    logic [7:0] b;
    logic       aborted;
    last_end = -100000;
    forever begin
      @(negedge clk);
      if (!reset && tx == 1'b0) begin
        start_cyc = cyc;
        aborted   = 1'b0;
        b         = '0;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          if (k == CPB / 2) check_eq("rx_start_bit", 32'(tx), 32'd0);
          else if (k == FRAME - CPB / 2) check_eq("rx_stop_bit", 32'(tx), 32'd1);
          else if (k > CPB && k < FRAME - CPB && (k % CPB) == CPB / 2)
            b[k / CPB - 1] = tx;
          if (k == FRAME - 2) check_eq("rx_done_early", 32'(tx_done_tick), 32'd0);
          if (k == FRAME - 1) check_eq("rx_done_last", 32'(tx_done_tick), 32'd1);
        end
        if (!aborted) begin
          rx_q.push_back(b);
          gap_q.push_back(start_cyc - last_end - 1);
          last_end = cyc;
          frames_seen++;
        end
      end
    end
  end

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_eq("frame_wait", 32'(frames_seen), 32'(target));
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done_tick && n < budget);
    check_eq("done_wait", 32'(tx_done_tick), 32'd1);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    gap_q.delete();
  endtask

  task automatic check_stream(input string tag, input logic [7:0] exp_q[$]);
    check_eq({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check_eq({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
      if (i > 0) check_eq({tag, "_gap"}, 32'(gap_q[i]), 32'd0);
    end
  endtask

  initial begin : stim
    logic [7:0] exp_q[$];
    logic       activity;
    int         f0;
    int         d0;

    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;

    // 1. reset values and quiet line
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_done", 32'(tx_done_tick), 32'd0);
    activity = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0 || empty !== 1'b1) activity = 1'b1;
    end
    check_eq("rst_quiet", 32'(activity), 32'd0);

    // 2. single byte latency and frame
    clear_rx();
    f0 = frames_seen;
    d0 = done_cnt;
    write_byte(8'hA5);
    check_eq("single_empty_n", 32'(empty), 32'd0);
    check_eq("single_tx_n", 32'(tx), 32'd1);
    @(negedge clk);
    check_eq("single_tx_n1", 32'(tx), 32'd0);
    check_eq("single_empty_n1", 32'(empty), 32'd1);
    check_eq("single_busy", 32'(tx_busy), 32'd1);
    wait_frames(f0 + 1, 3 * FRAME);
    exp_q = '{8'hA5};
    check_stream("single", exp_q);
    check_eq("single_busy_end", 32'(tx_busy), 32'd0);
    check_eq("single_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 3. burst: one byte pops at once, DEPTH more fill the FIFO, the rest drop
    clear_rx();
    exp_q.delete();
    f0 = frames_seen;
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      write_byte(8'(i + 1));
      if (i < DEPTH + 1) exp_q.push_back(8'(i + 1));
      if (i == DEPTH) check_eq("burst_full", 32'(full), 32'd1);
    end
    check_eq("burst_full_after_drop", 32'(full), 32'd1);
    wait_frames(f0 + exp_q.size(), (exp_q.size() + 2) * FRAME);
    check_stream("burst", exp_q);
    check_eq("burst_done_cnt", 32'(done_cnt - d0), 32'(exp_q.size()));
    check_eq("burst_empty", 32'(empty), 32'd1);
    check_eq("burst_full_end", 32'(full), 32'd0);

    // 4. write in the same cycle as the pop at frame end
    clear_rx();
    f0 = frames_seen;
    write_byte(8'h11);
    write_byte(8'h22);
    wait_done(2 * FRAME);
    write_byte(8'h3C);
    check_eq("simul_empty", 32'(empty), 32'd0);
    check_eq("simul_full", 32'(full), 32'd0);
    wait_done(2 * FRAME);
    @(negedge clk);
    check_eq("simul_empty_after", 32'(empty), 32'd1);
    wait_frames(f0 + 3, 3 * FRAME);
    exp_q = '{8'h11, 8'h22, 8'h3C};
    check_stream("simul", exp_q);

    // 5. reset during data bit 4 discards the frame and the queue
    clear_rx();
    write_byte(8'hFF);
    write_byte(8'h81);
    write_byte(8'h42);
    repeat (CPB * 5 + CPB / 2 - 1) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midrst_tx", 32'(tx), 32'd1);
    check_eq("midrst_empty", 32'(empty), 32'd1);
    check_eq("midrst_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    f0 = frames_seen;
    activity = 1'b0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) activity = 1'b1;
    end
    check_eq("midrst_quiet", 32'(activity), 32'd0);
    check_eq("midrst_frames", 32'(frames_seen - f0), 32'd0);

    // 6. stream 20 random bytes, keeping the FIFO non-full so pointers wrap several times
    clear_rx();
    exp_q.delete();
    f0 = frames_seen;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'($urandom_range(0, 255)));
      write_byte(exp_q[i]);
    end
    for (int i = 4; i < 20; i++) begin
      wait_done(2 * FRAME);
      repeat ($urandom_range(0, 40)) @(negedge clk);
      check_eq("stream_not_full", 32'(full), 32'd0);
      exp_q.push_back(8'($urandom_range(0, 255)));
      write_byte(exp_q[i]);
    end
    wait_frames(f0 + 20, 6 * FRAME);
    check_stream("stream", exp_q);
    check_eq("stream_empty", 32'(empty), 32'd1);
    check_eq("stream_idle_tx", 32'(tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
